// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package wb_arb_pkg;

   localparam int REG_AW = 5;
   localparam int XLEN   = 32;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] addr;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_WB   = 2'd1,
      GNT_LU   = 2'd2
   } gnt_src_e;

endpackage

// File: rtl/wb_arb_fifo.sv
// Long-latency result FIFO with per-entry valid bits; entries can be killed by
// address when a younger writeback write to the same register wins the port.
module wb_arb_fifo
   import wb_arb_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int XLEN  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic [REG_AW-1:0] push_addr_i,
   input  logic [XLEN-1:0]   push_data_i,
   input  logic              pop_i,
   input  logic              kill_i,
   input  logic [REG_AW-1:0] kill_addr_i,
   output logic              head_vld_o,
   output logic [REG_AW-1:0] head_addr_o,
   output logic [XLEN-1:0]   head_data_o,
   output logic              full_o,
   output logic              pop_o
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0]     rd_q, wr_q;
   logic [PW:0]       cnt_q, cnt_d;
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [REG_AW-1:0] addr_q [DEPTH];
   logic [XLEN-1:0]   data_q [DEPTH];
   logic              occ, skip, pop;

   assign occ         = (cnt_q != '0);
   assign head_vld_o  = occ & vld_q[rd_q];
   assign head_addr_o = addr_q[rd_q];
   assign head_data_o = data_q[rd_q];
   // A killed head slot is retired on its own, freeing space without a port cycle.
   assign skip        = occ & ~vld_q[rd_q];
   assign pop         = skip | (pop_i & head_vld_o);
   assign pop_o       = pop;
   assign full_o      = (cnt_q == (PW+1)'(DEPTH));

   always_comb begin
      vld_d = vld_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (kill_i && (addr_q[i] == kill_addr_i)) vld_d[i] = 1'b0;
      end
      if (pop)    vld_d[rd_q] = 1'b0;
      if (push_i) vld_d[wr_q] = 1'b1;
   end

   always_comb begin
      cnt_d = cnt_q;
      case ({push_i, pop})
         2'b10:   cnt_d = cnt_q + (PW+1)'(1);
         2'b01:   cnt_d = cnt_q - (PW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         vld_q <= '0;
      end else begin
         if (pop)    rd_q <= rd_q + PW'(1);
         if (push_i) wr_q <= wr_q + PW'(1);
         cnt_q <= cnt_d;
         vld_q <= vld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) begin
         addr_q[wr_q] <= push_addr_i;
         data_q[wr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: WB has priority, long-latency results drain
// into idle cycles or are forced through after MAX_WAIT losses. WB_ARB_PERF_EN adds perf_stall_cnt.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4,
   parameter int XLEN     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              lu_valid,
   output logic              lu_ready,
   input  logic [REG_AW-1:0] lu_addr,
   input  logic [XLEN-1:0]   lu_data,
   output logic              pipe_stall,
   output logic              rf_we,
   output logic [REG_AW-1:0] rf_addr,
   output logic [XLEN-1:0]   rf_data
`ifdef WB_ARB_PERF_EN
   ,
   output logic [31:0]       perf_stall_cnt
`endif
);

   localparam int CW = $clog2(MAX_WAIT + 1);

   gnt_src_e          gnt;
   logic              wb_req, head_vld, fifo_full, fifo_pop, starved, lu_push;
   logic [REG_AW-1:0] head_addr;
   logic [XLEN-1:0]   head_data;
   logic [CW-1:0]     wait_q, wait_d;
   logic              rf_we_q;
   logic [REG_AW-1:0] rf_addr_q;
   logic [XLEN-1:0]   rf_data_q;

   assign wb_req     = wb_valid & wb_we & (wb_addr != '0);
   assign starved    = head_vld & (wait_q == CW'(MAX_WAIT));
   assign pipe_stall = wb_req & starved;
   assign lu_ready   = ~fifo_full | fifo_pop;
   // x0 results are acknowledged but never stored.
   assign lu_push    = lu_valid & lu_ready & (lu_addr != '0);

   always_comb begin
      gnt = GNT_NONE;
      if (starved)       gnt = GNT_LU;
      else if (wb_req)   gnt = GNT_WB;
      else if (head_vld) gnt = GNT_LU;
   end

   always_comb begin
      wait_d = wait_q;
      if (!head_vld || gnt == GNT_LU) wait_d = '0;
      else if (wait_q != CW'(MAX_WAIT)) wait_d = wait_q + CW'(1);
   end

   wb_arb_fifo #(
      .DEPTH (DEPTH),
      .XLEN  (XLEN)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (lu_push),
      .push_addr_i (lu_addr),
      .push_data_i (lu_data),
      .pop_i       (gnt == GNT_LU),
      .kill_i      (gnt == GNT_WB),
      .kill_addr_i (wb_addr),
      .head_vld_o  (head_vld),
      .head_addr_o (head_addr),
      .head_data_o (head_data),
      .full_o      (fifo_full),
      .pop_o       (fifo_pop)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q    <= '0;
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
      end else begin
         wait_q  <= wait_d;
         rf_we_q <= (gnt != GNT_NONE);
         if (gnt == GNT_WB) begin
            rf_addr_q <= wb_addr;
            rf_data_q <= wb_data;
         end else if (gnt == GNT_LU) begin
            rf_addr_q <= head_addr;
            rf_data_q <= head_data;
         end
      end
   end

   assign rf_we   = rf_we_q;
   assign rf_addr = rf_addr_q;
   assign rf_data = rf_data_q;

`ifdef WB_ARB_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) perf_q <= '0;
      else        perf_q <= perf_q + 32'(pipe_stall);
   end

   assign perf_stall_cnt = perf_q;
`else
   // Stall cycles are visible only on pipe_stall in this build.
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: stimulus queues expected port writes,
// a negedge monitor retires them whenever rf_we is seen.
module tb_wb_port_arbiter;

   typedef struct packed {
      logic [4:0]  addr;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wb_valid = 1'b0, wb_we = 1'b0;
   logic [4:0]  wb_addr = '0;
   logic [31:0] wb_data = '0;
   logic        lu_valid = 1'b0;
   logic [4:0]  lu_addr = '0;
   logic [31:0] lu_data = '0;
   logic        lu_ready, pipe_stall, rf_we;
   logic [4:0]  rf_addr;
   logic [31:0] rf_data;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4), .XLEN(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wb_valid   (wb_valid),
      .wb_we      (wb_we),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .lu_valid   (lu_valid),
      .lu_ready   (lu_ready),
      .lu_addr    (lu_addr),
      .lu_data    (lu_data),
      .pipe_stall (pipe_stall),
      .rf_we      (rf_we),
      .rf_addr    (rf_addr),
      .rf_data    (rf_data)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wb(input logic v, input logic [4:0] a, input logic [31:0] d);
      wb_valid = v;
      wb_we    = v;
      wb_addr  = a;
      wb_data  = d;
   endtask

   task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d);
      lu_valid = v;
      lu_addr  = a;
      lu_data  = d;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rf_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write actual=x%0d/0x%0h required=no write", rf_addr, rf_data);
         end else begin
            e = exp_q.pop_front();
            check("rf_write", 64'({rf_addr, rf_data}), 64'({e.addr, e.data}));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_rf_we", rf_we, 0);
      check("reset_rf_addr", rf_addr, 0);
      check("reset_rf_data", rf_data, 0);
      check("reset_lu_ready", lu_ready, 1);
      check("reset_stall", pipe_stall, 0);
      rst_n = 1'b1;
      step();

      // Plain WB write, then a dropped x0 write.
      wb(1, 5'd5, 32'h1); expect_wr(5'd5, 32'h1);
      #1 check("wb_stall", pipe_stall, 0);
      step();
      wb(1, 5'd0, 32'hDEAD);
      #1 check("x0_stall", pipe_stall, 0);
      step();
      wb(0, 0, 0);
      step();

      // Idle-port drain of one long-latency result.
      lu(1, 5'd7, 32'h77);
      #1 check("lu_ready_empty", lu_ready, 1);
      step();
      lu(0, 0, 0); expect_wr(5'd7, 32'h77);
      #1 check("drain_stall", pipe_stall, 0);
      step();
      check("lu_ready_drained", lu_ready, 1);
      step();

      // Starvation: four losses, forced drain with stall, then held WB.
      lu(1, 5'd3, 32'h33);
      step();
      lu(0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         wb(1, 5'd9, 32'h91 + i); expect_wr(5'd9, 32'h91 + i);
         #1 check("starve_lose_stall", pipe_stall, 0);
         step();
      end
      wb(1, 5'd9, 32'h95); expect_wr(5'd3, 32'h33);
      #1 check("starve_forced_stall", pipe_stall, 1);
      step();
      expect_wr(5'd9, 32'h95);
      #1 check("starve_release_stall", pipe_stall, 0);
      step();
      wb(0, 0, 0);
      step();

      // Younger WB write kills the queued entry for the same register.
      lu(1, 5'd4, 32'hA);
      step();
      lu(0, 0, 0);
      wb(1, 5'd4, 32'hB); expect_wr(5'd4, 32'hB);
      #1 check("kill_stall", pipe_stall, 0);
      step();
      wb(0, 0, 0);
      repeat (2) step();

      // lu_addr=0 is acknowledged and dropped.
      lu(1, 5'd0, 32'hBAD);
      #1 check("lu_x0_ready", lu_ready, 1);
      step();
      lu(0, 0, 0);
      repeat (2) step();

      // Fill to full under WB pressure, then drain in push order.
      wb(1, 5'd10, 32'hA0); lu(1, 5'd11, 32'h1B1); expect_wr(5'd10, 32'hA0);
      #1 check("fill_ready0", lu_ready, 1);
      step();
      wb(1, 5'd10, 32'hA1); lu(1, 5'd12, 32'h1C2); expect_wr(5'd10, 32'hA1);
      #1 check("fill_ready1", lu_ready, 1);
      step();
      lu(1, 5'd13, 32'h1D3);
      for (int i = 2; i < 5; i++) begin
         wb(1, 5'd10, 32'hA0 + i); expect_wr(5'd10, 32'hA0 + i);
         #1 check("full_ready", lu_ready, 0);
         check("full_stall", pipe_stall, 0);
         step();
      end
      wb(1, 5'd10, 32'hA5); expect_wr(5'd11, 32'h1B1);
      #1 check("full_pop_ready", lu_ready, 1);
      check("full_pop_stall", pipe_stall, 1);
      step();
      lu(1, 5'd14, 32'h1E4); expect_wr(5'd10, 32'hA5);
      #1 check("full_hold_ready", lu_ready, 0);
      check("full_hold_stall", pipe_stall, 0);
      step();
      wb(0, 0, 0); expect_wr(5'd12, 32'h1C2);
      #1 check("drain_pop_ready", lu_ready, 1);
      step();
      lu(0, 0, 0); expect_wr(5'd13, 32'h1D3);
      step();
      expect_wr(5'd14, 32'h1E4);
      repeat (2) step();

      // Reset while a granted result is in flight: nothing is written.
      lu(1, 5'd15, 32'hF);
      step();
      lu(0, 0, 0);
      #1 rst_n = 1'b0;
      #1 check("midrst_rf_we", rf_we, 0);
      check("midrst_lu_ready", lu_ready, 1);
      step();
      rst_n = 1'b1;
      repeat (3) step();

      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
